// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus of the fetch stage.
//   imem_req_valid  - fetch unit presents a word request
//   imem_req_ready  - memory accepts the request this cycle
//   imem_req_addr   - word-aligned fetch address
//   imem_resp_valid - response word valid (in order, no back-pressure)
//   imem_resp_data  - returned instruction word
// master: fetch unit side; slave: instruction memory side.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the fetch PC, issues in-order
// word requests, queues returned words (with their PCs) in a prefetch FIFO
// and presents one instruction per cycle to decode. Redirects flush the FIFO
// and discard responses still in flight.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   imem              - instruction memory bus (fetch_unit_if.master)
//   redirect_valid/pc - taken branch/jump target from EX (pc[1:0] ignored)
//   stall_d           - decode holds the current instruction
//   instr_valid       - instr/instr_pc valid for decode
//   instr             - instruction word, addi x0,x0,0 when not valid
//   instr_pc          - PC of instr (0 when not valid)
//   instr_pc_plus4    - instr_pc + 4, wrapping
//
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode when the FIFO is empty (zero response-to-decode latency).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        imem,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                stall_d,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [31:0]         instr_pc,
    output logic [31:0]         instr_pc_plus4
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, inflight_q, drop_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;   // PC of the next response that will be kept
    logic          run_q;       // holds off requests while in reset

    logic [CW:0]   occupancy;
    logic          req_valid, req_fire;
    logic          keep_resp, drop_resp;
    logic          fifo_empty, bypass;
    logic          push, pop;
    logic          out_valid;
    logic [31:0]   out_word, out_pc;
    logic [31:0]   target_pc;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign fifo_empty     = (count_q == '0);

    // Credits: queued words plus outstanding requests never exceed DEPTH,
    // so every accepted response always has a FIFO slot.
    assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
    assign req_valid = run_q && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign req_fire  = req_valid && imem.imem_req_ready;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    assign keep_resp = imem.imem_resp_valid && !redirect_valid && (drop_q == '0);
    assign drop_resp = imem.imem_resp_valid && !redirect_valid && (drop_q != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass   = keep_resp && fifo_empty;
    assign out_word = fifo_empty ? imem.imem_resp_data : word_q[rd_ptr_q];
    assign out_pc   = fifo_empty ? resp_pc_q : pc_q[rd_ptr_q];
`else
    assign bypass   = 1'b0;
    assign out_word = word_q[rd_ptr_q];
    assign out_pc   = pc_q[rd_ptr_q];
`endif

    assign out_valid = !redirect_valid && (!fifo_empty || bypass);
    assign pop       = !redirect_valid && !fifo_empty && !stall_d;
    // A bypassed word consumed by decode this cycle is never queued.
    assign push      = keep_resp && !(bypass && !stall_d);

    assign instr_valid    = out_valid;
    assign instr          = out_valid ? out_word : NOP;
    assign instr_pc       = out_valid ? out_pc : '0;
    assign instr_pc_plus4 = instr_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                // Everything still outstanding is stale; a response landing
                // this cycle is discarded directly and is not counted.
                fetch_pc_q <= target_pc;
                resp_pc_q  <= target_pc;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                inflight_q <= inflight_q - CW'(imem.imem_resp_valid);
                drop_q     <= inflight_q - CW'(imem.imem_resp_valid);
            end else begin
                if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (keep_resp) resp_pc_q <= resp_pc_q + 32'd4;
                if (drop_resp) drop_q <= drop_q - CW'(1);
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q    <= count_q + CW'(push) - CW'(pop);
                inflight_q <= inflight_q + CW'(req_fire) - CW'(imem.imem_resp_valid);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= imem.imem_resp_data;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (default build, DEPTH=4,
// RESET_PC=0x100). The memory model returns ~addr after 1 or 3 cycles.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    int total;
    int bad;
    int unsigned lat;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: fixed-latency pipe, word = ~address.
    logic [2:0]  pv;
    logic [31:0] pa [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[1:0], bus.imem_req_valid && bus.imem_req_ready};
            pa[0] <= bus.imem_req_addr;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
        end
    end

    assign bus.imem_resp_valid = (lat == 3) ? pv[2] : pv[0];
    assign bus.imem_resp_data  = (lat == 3) ? ~pa[2] : ~pa[0];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_instr(input logic [31:0] pc, input logic [31:0] pc4);
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check("wait_valid", {31'd0, instr_valid}, 32'd1);
        check("seq_pc", instr_pc, pc);
        check("seq_pc4", instr_pc_plus4, pc4);
        check("seq_instr", instr, ~pc);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        lat = 1;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        stall_d = 1'b0;
        bus.imem_req_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0000_0100);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_pc4", instr_pc_plus4, 32'h4);
        rst_n = 1'b1;

        // Streaming from RESET_PC with 1-cycle memory
        tick();
        check("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("first_req_addr", bus.imem_req_addr, 32'h0000_0100);
        tick();
        check("second_req_addr", bus.imem_req_addr, 32'h0000_0104);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("stream_valid", {31'd0, instr_valid}, 32'd1);
            check("stream_pc", instr_pc, 32'h100 + 32'(4 * k));
            check("stream_instr", instr, ~(32'h100 + 32'(4 * k)));
        end
        check("stream_pc4", instr_pc_plus4, 32'h0000_0120);

        // Memory not ready for 5 cycles
        bus.imem_req_ready = 1'b0;
        tick();
        check("nrdy_last_pc", instr_pc, 32'h0000_0120);
        check("nrdy_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("nrdy_req_addr", bus.imem_req_addr, 32'h0000_0124);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("nrdy_instr_valid", {31'd0, instr_valid}, 32'd0);
            check("nrdy_hold_valid", {31'd0, bus.imem_req_valid}, 32'd1);
            check("nrdy_hold_addr", bus.imem_req_addr, 32'h0000_0124);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        check("rdy_next_addr", bus.imem_req_addr, 32'h0000_0128);
        check("rdy_instr_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("rdy_resume_pc", instr_pc, 32'h0000_0124);

        // Decode stall for 6 cycles: credits cap queued + in-flight at 4
        stall_d = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stall_hold_pc", instr_pc, 32'h0000_0124);
            check("stall_req_valid", {31'd0, bus.imem_req_valid}, (k == 0) ? 32'd1 : 32'd0);
        end
        stall_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("unstall_valid", {31'd0, instr_valid}, 32'd1);
            check("unstall_pc", instr_pc, 32'h128 + 32'(4 * k));
        end

        // Drain, then switch to 3-cycle memory
        bus.imem_req_ready = 1'b0;
        repeat (6) tick();
        check("drained_valid", {31'd0, instr_valid}, 32'd0);
        lat = 3;
        bus.imem_req_ready = 1'b1;
        repeat (3) tick();

        // Redirect with three requests in flight
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2003;
        #1;
        check("redir_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        check("redir_instr_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_tgt_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("redir_tgt_addr", bus.imem_req_addr, 32'h0000_2000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("redir_stale_dropped", {31'd0, instr_valid}, 32'd0);
        end
        tick();
        check("redir_first_valid", {31'd0, instr_valid}, 32'd1);
        check("redir_first_pc", instr_pc, 32'h0000_2000);
        check("redir_first_pc4", instr_pc_plus4, 32'h0000_2004);
        check("redir_first_instr", instr, ~32'h0000_2000);

        // Fill the FIFO under stall, then redirect while stalled
        stall_d = 1'b1;
        repeat (5) tick();
        check("full_head_pc", instr_pc, 32'h0000_2000);
        check("full_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFA;
        #1;
        check("rs_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rs_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rs_flushed", {31'd0, instr_valid}, 32'd0);
        check("rs_tgt_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("rs_tgt_addr", bus.imem_req_addr, 32'hFFFF_FFF8);

        // Address wrap at the top of memory
        tick();
        check("wrap_addr_fffc", bus.imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr_zero", bus.imem_req_addr, 32'h0000_0000);
        stall_d = 1'b0;
        next_instr(32'hFFFF_FFF8, 32'hFFFF_FFFC);
        next_instr(32'hFFFF_FFFC, 32'h0000_0000);
        next_instr(32'h0000_0000, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
